// File: rtl/image_pkg.sv
// image_pkg: shared constants and FSM state type for the image reader
package image_pkg;
    localparam int N      = 8;
    localparam int S      = 30;
    localparam int H      = 30;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
endpackage

// File: rtl/pixel_scan_counter.sv
// pixel_scan_counter: raster col/row counter with row-wrap and frame position flags
module pixel_scan_counter #(
    parameter int S = image_pkg::S,
    parameter int H = image_pkg::H,
    parameter int W = image_pkg::ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] col,
    output logic [W-1:0] row,
    output logic         first,
    output logic         eol,
    output logic         last
);
    import image_pkg::*;

    assign first = (col == '0) && (row == '0);
    assign eol   = (col == W'(S - 1));
    assign last  = eol && (row == W'(H - 1));

    // col counts across a row and wraps into the next row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            col <= eol ? '0 : col + W'(1);
            row <= eol ? row + W'(1) : row;
        end
    end
endmodule

// File: rtl/image_reader.sv
// image_reader: streams a stored S x H image out of a result RAM in raster order
module image_reader #(
    parameter int N = image_pkg::N,
    parameter int S = image_pkg::S,
    parameter int H = image_pkg::H
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [image_pkg::ADDR_W-1:0] rd_addr,
    input  logic [N-1:0]                rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                out_data,
    output logic                        out_sof,
    output logic                        out_eol,
    output logic                        out_eof,
    output logic                        busy,
    output logic                        done
);
    import image_pkg::*;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] col, row;
    logic              first, eol, last;
    logic              load, accept, clear, advance;

    // the output register refills whenever it is empty or its pixel leaves this cycle
    assign accept  = out_valid && out_ready;
    assign load    = (state == READ) && (!out_valid || out_ready);
    assign clear   = (state == IDLE) && start;
    assign advance = load && !last;
    assign rd_addr = ADDR_W'(row * S + col);

    pixel_scan_counter #(.S(S), .H(H), .W(ADDR_W)) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (advance),
        .col     (col),
        .row     (row),
        .first   (first),
        .eol     (eol),
        .last    (last)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: the last pixel load parks in DRAIN until the sink takes it
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? READ : IDLE;
            READ:    state_nx = (load && last) ? DRAIN : READ;
            DRAIN:   state_nx = accept ? FIN : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // status outputs decoded from state
    always_comb begin
        busy = (state == READ) || (state == DRAIN);
        done = (state == FIN);
    end

    // output pixel register with position flags captured alongside the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
            out_sof   <= first;
            out_eol   <= eol;
            out_eof   <= last;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_image_reader.sv
// tb_image_reader: directed and random-backpressure frame readouts against a raster model
module tb_image_reader;
    import image_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, start, out_ready;
    logic [9:0] rd_addr;
    logic [7:0] rd_data, out_data;
    logic       out_valid, out_sof, out_eol, out_eof, busy, done;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int k, cyc, fin_ticks, done_cyc;

    image_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .busy      (busy),
        .done      (done)
    );

    // result RAM contents: RAM[a] = a[7:0]
    assign rd_data = rd_addr[7:0];

    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // one cycle: drive at negedge, check the model for the pixel index k, then clock
    task automatic tick(input bit r, input bit s);
        int col;
        out_ready = r;
        start     = s;
        #1;
        col = k % S;
        if (cyc == 2) chk("latency_idle", 32'(out_valid), 0);
        if (cyc == 3) chk("latency_first", 32'(out_valid), 1);
        chk("busy", 32'(busy), 32'(cyc >= 2 && k < S * H));
        chk("done", 32'(done), 32'(k == S * H && fin_ticks == 0));
        if (done) done_cyc = cyc;
        if (k == S * H) begin
            fin_ticks++;
            chk("valid_after_eof", 32'(out_valid), 0);
        end else if (out_valid) begin
            chk("pixel", {out_data, out_sof, out_eol, out_eof},
                {8'(k), k == 0, col == S - 1, k == S * H - 1});
            chk("rd_addr", 32'(rd_addr), (k + 1 < S * H) ? k + 1 : k);
            if (k == 0)   chk("px_0_0", {out_data, out_sof}, {8'h00, 1'b1});
            if (k == 29)  chk("px_0_29", {rd_addr, out_data, out_eol}, {10'd30, 8'h1D, 1'b1});
            if (k == 30)  chk("px_1_0", out_data, 8'h1E);
            if (k == 101) chk("px_after_stall", out_data, 8'h65);
            if (k == 899) chk("px_last", {rd_addr, out_data, out_eof}, {10'd899, 8'h83, 1'b1});
            if (r) k++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // mode 0: ready held high; 1: stall at pixel 100, start at 50 and in FIN; 2: random ready
    task automatic run_frame(input int mode, input int stop_at);
        int stalls;
        bit r;
        stalls    = 0;
        k         = 0;
        cyc       = 1;
        fin_ticks = 0;
        done_cyc  = 0;
        for (int i = 0; i < 5000 && fin_ticks == 0; i++) begin
            if (stop_at >= 0 && k == stop_at) return;
            r = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 1 && k == 100 && stalls < 5) begin
                r = 1'b0;
                stalls++;
            end
            tick(r, i == 0 || (mode == 1 && (k == 50 || k == S * H)));
        end
        chk("frame_complete", 32'(fin_ticks), 1);
        chk("pixel_count", 32'(k), S * H);
        if (mode == 0) chk("done_cycle", 32'(done_cyc), S * H + 3);
        if (mode == 1) chk("done_cycle_stall", 32'(done_cyc), S * H + 3 + 5);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("reset", {out_valid, out_data, out_sof, out_eol, out_eof, busy, done, rd_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release", {out_valid, out_data, out_sof, out_eol, out_eof, busy, done, rd_addr}, 0);

        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, -1);

        run_frame(0, 400);
        #1 rst_n = 1'b0;
        #1 chk("reset_mid", {out_valid, out_data, out_sof, out_eol, out_eof, busy, done, rd_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_mid_release", {out_valid, out_data, out_sof, out_eol, out_eof, busy, done, rd_addr}, 0);
        @(negedge clk);
        chk("reset_mid_idle", {out_valid, busy, done}, 0);
        run_frame(0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
